// File: rtl/mic_frame_pkg.sv
// Shared types and constants for the microphone framer.
//   frame_state_t : framer FSM states (FILL / EMIT)
//   clog2         : ceiling log2 for sizing localparams
//   TUSER_W       : width of the output in-frame index (tuser)
//   FRAME_CNT_W   : width of the completed-frame counter
package mic_frame_pkg;

  localparam int unsigned TUSER_W     = 16;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } frame_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mic_frame_ram.sv
// Simple dual-port RAM, DEPTH x DATA_W: synchronous write, registered read.
// The read register only updates on i_re, so it holds its word while the
// consumer is stalled.
//   i_clk              clock
//   i_we/i_waddr/i_wdata  write port
//   i_re/i_raddr       read port, data on o_rdata one cycle later
module mic_frame_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned AW     = 11
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port
  always_ff @(posedge i_clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/mic_frame_buffer.sv
// Framer between the mic AXI-Stream source and the FFT AXIS input.
// Samples go into a circular buffer of 2*FRAME_LEN words; overlapping frames
// of FRAME_LEN samples are emitted, one new frame every HOP_LEN samples, with
// tlast on the final sample and the in-frame index on tuser.
// Ports:
//   aclk, aresetn                 clock, async active-low reset
//   S_AXIS_MIC_DATA_*             mic sample input (tlast ignored)
//   M_AXIS_FRAME_*                framed output (tdata/tvalid/tready/tlast/tuser)
//   frame_cnt                     frames fully emitted (wraps)
//   overrun_cnt                   dropped input beats (MIC_FRAME_BUFFER_OVERRUN_EN only)
// Build option MIC_FRAME_BUFFER_OVERRUN_EN: input never stalls; beats arriving
// with the buffer full are dropped and counted.
module mic_frame_buffer
  import mic_frame_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned HOP_LEN   = 512
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [DATA_W-1:0]      S_AXIS_MIC_DATA_tdata,
  input  logic                   S_AXIS_MIC_DATA_tvalid,
  input  logic                   S_AXIS_MIC_DATA_tlast,
  output logic                   S_AXIS_MIC_DATA_tready,
  output logic [DATA_W-1:0]      M_AXIS_FRAME_tdata,
  output logic                   M_AXIS_FRAME_tvalid,
  input  logic                   M_AXIS_FRAME_tready,
  output logic                   M_AXIS_FRAME_tlast,
  output logic [TUSER_W-1:0]     M_AXIS_FRAME_tuser,
`ifdef MIC_FRAME_BUFFER_OVERRUN_EN
  output logic [15:0]            overrun_cnt,
`endif
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned DEPTH = 2 * FRAME_LEN;
  localparam int unsigned AW    = clog2(DEPTH) + 1;
  localparam int unsigned RAW   = AW - 1;
  localparam int unsigned IW    = clog2(FRAME_LEN);

  logic [AW-1:0]          r_wr_ptr, r_fs_ptr;
  logic [AW-1:0]          w_avail, w_wr_ptr_nxt, w_fs_ptr_nxt;
  logic [IW:0]            r_rd_idx;
  frame_state_t           r_state;
  logic                   r_q_vld, r_q_last;
  logic [IW-1:0]          r_q_idx;
  logic                   r_o_vld, r_o_last;
  logic [IW-1:0]          r_o_idx;
  logic [DATA_W-1:0]      r_o_data;
  logic [DATA_W-1:0]      w_ram_q;
  logic [RAW-1:0]         w_rd_addr;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   w_wr, w_rd, w_acc, w_head_last, w_frame_done, w_q_hold, w_m_vld;
  logic                   w_unused_tlast;

  assign w_unused_tlast = S_AXIS_MIC_DATA_tlast;

  assign w_avail = r_wr_ptr - r_fs_ptr;

  // Output pair: O (older) then Q (RAM read register); head is O when valid.
  assign w_m_vld      = r_o_vld | r_q_vld;
  assign w_acc        = w_m_vld & M_AXIS_FRAME_tready;
  assign w_head_last  = r_o_vld ? r_o_last : r_q_last;
  assign w_frame_done = w_acc & w_head_last;
  // Q cannot drain this cycle, so a new read would clobber it.
  assign w_q_hold     = r_q_vld & r_o_vld & ~M_AXIS_FRAME_tready;
  assign w_rd         = (r_state == EMIT) && (r_rd_idx < (IW+1)'(FRAME_LEN)) && !w_q_hold;
  assign w_rd_addr    = r_fs_ptr[RAW-1:0] + r_rd_idx;

  assign w_wr_ptr_nxt = w_wr ? r_wr_ptr + AW'(1) : r_wr_ptr;
  assign w_fs_ptr_nxt = w_frame_done ? r_fs_ptr + AW'(HOP_LEN) : r_fs_ptr;

`ifdef MIC_FRAME_BUFFER_OVERRUN_EN
  logic [15:0] r_overrun_cnt;

  assign w_wr                   = S_AXIS_MIC_DATA_tvalid & (w_avail != AW'(DEPTH));
  assign S_AXIS_MIC_DATA_tready = 1'b1;
  assign overrun_cnt            = r_overrun_cnt;

  // Saturating count of beats dropped while the buffer is full
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_overrun_cnt <= '0;
    end else if (S_AXIS_MIC_DATA_tvalid && (w_avail == AW'(DEPTH)) &&
                 (r_overrun_cnt != 16'hFFFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 16'd1;
    end
  end
`else
  logic          r_s_tready;
  logic [AW-1:0] w_avail_nxt;

  assign w_avail_nxt            = w_wr_ptr_nxt - w_fs_ptr_nxt;
  assign w_wr                   = S_AXIS_MIC_DATA_tvalid & r_s_tready;
  assign S_AXIS_MIC_DATA_tready = r_s_tready;

  // Input ready for next cycle, from post-update pointers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_s_tready <= 1'b0;
    else          r_s_tready <= (w_avail_nxt < AW'(DEPTH));
  end
`endif

  mic_frame_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAW)
  ) u_ram (
    .i_clk   (aclk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr[RAW-1:0]),
    .i_wdata (S_AXIS_MIC_DATA_tdata),
    .i_re    (w_rd),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_q)
  );

  // Pointers, frame counter and framing FSM
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr    <= '0;
      r_fs_ptr    <= '0;
      r_rd_idx    <= '0;
      r_frame_cnt <= '0;
      r_state     <= FILL;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_fs_ptr <= w_fs_ptr_nxt;
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      case (r_state)
        FILL: begin
          if (w_avail >= AW'(FRAME_LEN)) begin
            r_state  <= EMIT;
            r_rd_idx <= '0;
          end
        end
        EMIT: begin
          if (w_rd)         r_rd_idx <= r_rd_idx + (IW+1)'(1);
          if (w_frame_done) r_state  <= FILL;
        end
        default: r_state <= FILL;
      endcase
    end
  end

  // Q-stage tags and O-stage skid register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_q_vld  <= 1'b0;
      r_q_last <= 1'b0;
      r_q_idx  <= '0;
      r_o_vld  <= 1'b0;
      r_o_last <= 1'b0;
      r_o_idx  <= '0;
      r_o_data <= '0;
    end else begin
      if (w_rd) begin
        r_q_vld  <= 1'b1;
        r_q_last <= (r_rd_idx == (IW+1)'(FRAME_LEN - 1));
        r_q_idx  <= r_rd_idx[IW-1:0];
      end else if (r_q_vld && !w_q_hold) begin
        r_q_vld <= 1'b0;
      end

      if (r_o_vld) begin
        if (M_AXIS_FRAME_tready) begin
          r_o_vld <= r_q_vld;
          if (r_q_vld) begin
            r_o_data <= w_ram_q;
            r_o_last <= r_q_last;
            r_o_idx  <= r_q_idx;
          end
        end
      end else if (r_q_vld && !M_AXIS_FRAME_tready) begin
        r_o_vld  <= 1'b1;
        r_o_data <= w_ram_q;
        r_o_last <= r_q_last;
        r_o_idx  <= r_q_idx;
      end
    end
  end

  assign M_AXIS_FRAME_tvalid = w_m_vld;
  assign M_AXIS_FRAME_tdata  = r_o_vld ? r_o_data : (r_q_vld ? w_ram_q : '0);
  assign M_AXIS_FRAME_tlast  = r_o_vld ? r_o_last : (r_q_vld & r_q_last);
  assign M_AXIS_FRAME_tuser  = r_o_vld ? TUSER_W'(r_o_idx) :
                               (r_q_vld ? TUSER_W'(r_q_idx) : '0);
  assign frame_cnt           = r_frame_cnt;

endmodule

// File: tb/tb_mic_frame_buffer.sv
// Scoreboard bench for mic_frame_buffer with FRAME_LEN=8, HOP_LEN=4.
// Build with MIC_FRAME_BUFFER_OVERRUN_EN to exercise the drop/count option.
module tb_mic_frame_buffer;

  localparam int FL    = 8;
  localparam int HOP   = 4;
  localparam int DEPTH = 16;
`ifdef MIC_FRAME_BUFFER_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] user;
    logic        last;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [15:0] m_tuser;
  logic [15:0] frame_cnt;
`ifdef MIC_FRAME_BUFFER_OVERRUN_EN
  logic [15:0] overrun_cnt;
`endif

  always #5 aclk = ~aclk;

  mic_frame_buffer #(
    .DATA_W    (32),
    .FRAME_LEN (FL),
    .HOP_LEN   (HOP)
  ) dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .S_AXIS_MIC_DATA_tdata  (s_tdata),
    .S_AXIS_MIC_DATA_tvalid (s_tvalid),
    .S_AXIS_MIC_DATA_tlast  (s_tlast),
    .S_AXIS_MIC_DATA_tready (s_tready),
    .M_AXIS_FRAME_tdata     (m_tdata),
    .M_AXIS_FRAME_tvalid    (m_tvalid),
    .M_AXIS_FRAME_tready    (m_tready),
    .M_AXIS_FRAME_tlast     (m_tlast),
    .M_AXIS_FRAME_tuser     (m_tuser),
`ifdef MIC_FRAME_BUFFER_OVERRUN_EN
    .overrun_cnt            (overrun_cnt),
`endif
    .frame_cnt              (frame_cnt)
  );

  // Scoreboard state
  beat_t       exp_q[$];
  logic [31:0] acc[$];
  int          next_fs = 0;
  int          model_frames = 0;
  int          done_frames = 0;
  bit          stalled = 1'b0;
  bit          in_frame = 1'b0;
  logic [48:0] held = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    acc.delete();
    next_fs      = 0;
    model_frames = 0;
    done_frames  = 0;
    stalled      = 1'b0;
    in_frame     = 1'b0;
  endtask

  // Monitor: records accepted inputs (building expected frames), then checks outputs.
  initial begin : monitor
    beat_t b;
    beat_t e;
    int    avail;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (s_tvalid && s_tready) begin
          avail = acc.size() - done_frames * HOP;
          if (!(OVR && avail >= DEPTH)) begin
            acc.push_back(s_tdata);
            while (acc.size() >= next_fs + FL) begin
              for (int i = 0; i < FL; i++) begin
                b.data = acc[next_fs + i];
                b.user = 16'(i);
                b.last = (i == FL - 1);
                exp_q.push_back(b);
              end
              next_fs += HOP;
              model_frames++;
            end
          end
        end
        if (stalled) begin
          chk("stall_valid", 64'(m_tvalid), 64'd1);
          chk("stall_hold", 64'({m_tdata, m_tuser, m_tlast}), 64'(held));
        end
        if (in_frame) chk("no_gap", 64'(m_tvalid), 64'd1);
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0h required=none", m_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 64'(m_tdata), 64'(e.data));
            chk("beat_user", 64'(m_tuser), 64'(e.user));
            chk("beat_last", 64'(m_tlast), 64'(e.last));
          end
          in_frame = !m_tlast;
          if (m_tlast) done_frames++;
        end
        stalled = m_tvalid && !m_tready;
        held    = {m_tdata, m_tuser, m_tlast};
      end
    end
  end

  task automatic do_reset();
    s_tvalid = 1'b0;
    aresetn  = 1'b0;
    flush_model();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [31:0] v, input int bound, output bit ok);
    s_tdata  = v;
    s_tvalid = 1'b1;
    ok       = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge aclk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 1000; c++) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !m_tvalid) break;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : stim
    bit ok;
    bit found;
    bit rdy_done;
    int cnt;

    // Reset state (async assert)
    #3;
    aresetn = 1'b0;
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'(OVR));
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_m_tuser", 64'(m_tuser), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    do_reset();

    // Overlapping frames: 0..7, 4..11, 8..15
    m_tready = 1'b1;
    for (int v = 0; v < 7; v++) send(32'(v), 20, ok);
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      chk("early_no_valid", 64'(m_tvalid), 64'd0);
    end
    @(posedge aclk);
    #1;
    for (int v = 7; v < 16; v++) send(32'(v), 20, ok);
    drain();
    chk("hop_frame_cnt", 64'(frame_cnt), 64'd3);

`ifdef MIC_FRAME_BUFFER_OVERRUN_EN
    // Overrun: 20 beats into a stalled framer, 16 kept, 4 dropped
    do_reset();
    m_tready = 1'b0;
    cnt = 0;
    for (int v = 0; v < 20; v++) begin
      send(32'(500 + v), 2, ok);
      if (ok) cnt++;
      chk("ovr_s_tready", 64'(s_tready), 64'd1);
    end
    chk("ovr_accepted", 64'(cnt), 64'd20);
    chk("ovr_count", 64'(overrun_cnt), 64'd4);
    m_tready = 1'b1;
    drain();
    chk("ovr_frame_cnt", 64'(frame_cnt), 64'd3);
`else
    // Backpressure: exactly 16 accepted with output stalled
    do_reset();
    m_tready = 1'b0;
    cnt = 0;
    for (int v = 0; v < 16; v++) begin
      send(32'(100 + v), 5, ok);
      if (ok) cnt++;
    end
    chk("bp_accepted", 64'(cnt), 64'd16);
    send(32'd116, 10, ok);
    chk("bp_blocked", 64'(ok), 64'd0);
    chk("bp_s_tready", 64'(s_tready), 64'd0);
    m_tready = 1'b1;
    send(32'd116, 50, ok);
    chk("bp_resume", 64'(ok), 64'd1);
    for (int v = 117; v < 124; v++) send(32'(v), 50, ok);
    drain();
    chk("bp_frame_cnt", 64'(frame_cnt), 64'd5);
`endif

    // Reset in the middle of frame 1
    do_reset();
    m_tready = 1'b1;
    for (int v = 0; v < 12; v++) send(32'(200 + v), 20, ok);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge aclk);
      if (frame_cnt == 16'd1 && m_tvalid && m_tuser == 16'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("midrst_reached", 64'(found), 64'd1);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_m_tlast", 64'(m_tlast), 64'd0);
    chk("midrst_m_tuser", 64'(m_tuser), 64'd0);
    chk("midrst_m_tdata", 64'(m_tdata), 64'd0);
    chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'(OVR));
    flush_model();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    for (int v = 0; v < 8; v++) send(32'(300 + v), 20, ok);
    drain();
    chk("post_rst_frames", 64'(frame_cnt), 64'd1);

    // Random valid/ready toggling
    do_reset();
    rdy_done = 1'b0;
    fork
      begin
        for (int v = 0; v < 300; v++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge aclk);
            #1;
          end
          send(32'(1000 + v), 200, ok);
        end
        rdy_done = 1'b1;
      end
      begin
        while (!rdy_done) begin
          @(posedge aclk);
          #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_tready = 1'b1;
    drain();
    chk("rand_frame_cnt", 64'(frame_cnt), 64'(model_frames));
    if (!OVR) chk("rand_frames_total", 64'(frame_cnt), 64'd74);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
